// File: rtl/multi_mode_ring_counter.sv
// Ring / Johnson shift-register counter with direction, load, position index and wrap pulse.
// Optional illegal-state self-correction is compiled in with `define RING_SELF_CORRECT_EN.
module multi_mode_ring_counter #(
    parameter int N  = 8,
    parameter int PW = $clog2(2*N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          dir,
    input  logic          mode,
    input  logic          load,
    input  logic [N-1:0]  load_val,
    output logic [N-1:0]  Q,
    output logic [PW-1:0] pos,
    output logic          wrap,
    output logic          err
);

    localparam logic [PW:0] PERIOD_RING = (PW+1)'(N);
    localparam logic [PW:0] PERIOD_JOHN = (PW+1)'(2*N);
    localparam logic [N-1:0] START_RING = N'(1);
    localparam logic [N-1:0] START_JOHN = '0;

    logic [N-1:0]  q_q, q_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          mode_q, mode_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;

    logic [PW:0]   period;
    logic [PW:0]   pos_ext;
    logic [PW:0]   pos_inc;
    logic [PW:0]   pos_dec;
    logic [N-1:0]  shifted;
    logic          illegal;

    always_ff @(posedge clk) begin
        q_q    <= q_d;
        pos_q  <= pos_d;
        mode_q <= mode_d;
        wrap_q <= wrap_d;
        err_q  <= err_d;
    end

`ifdef RING_SELF_CORRECT_EN
    // Ring codes must be one-hot; Johnson codes may change value at most once along the word.
    always_comb begin
        int ones;
        int edges;
        ones  = 0;
        edges = 0;
        for (int i = 0; i < N; i++) begin
            ones += int'(q_q[i]);
        end
        for (int i = 0; i < N-1; i++) begin
            edges += int'(q_q[i] ^ q_q[i+1]);
        end
        illegal = mode_q ? (edges > 1) : (ones != 1);
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        period  = mode_q ? PERIOD_JOHN : PERIOD_RING;
        pos_ext = {1'b0, pos_q};
        pos_inc = pos_ext + (PW+1)'(1);
        pos_dec = (pos_q == '0) ? (period - (PW+1)'(1)) : (pos_ext - (PW+1)'(1));
        if (dir == 1'b0) begin
            shifted = {q_q[N-2:0], mode_q ? ~q_q[N-1] : q_q[N-1]};
        end else begin
            shifted = {mode_q ? ~q_q[0] : q_q[0], q_q[N-1:1]};
        end
    end

    always_comb begin
        q_d    = q_q;
        pos_d  = pos_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (reset) begin
            q_d    = mode ? START_JOHN : START_RING;
            pos_d  = '0;
            mode_d = mode;
        end else if (load) begin
            q_d    = load_val;
            pos_d  = '0;
            mode_d = mode;
        end else if (mode != mode_q) begin
            q_d    = mode ? START_JOHN : START_RING;
            pos_d  = '0;
            mode_d = mode;
        end else if (en) begin
            if (illegal) begin
                q_d   = mode_q ? START_JOHN : START_RING;
                pos_d = '0;
                err_d = 1'b1;
            end else begin
                q_d = shifted;
                // Wrap fires when crossing the origin in either direction.
                if (dir == 1'b0) begin
                    if (pos_inc == period) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_inc[PW-1:0];
                    end
                end else begin
                    pos_d  = pos_dec[PW-1:0];
                    wrap_d = (pos_q == '0);
                end
            end
        end
    end

    assign Q    = q_q;
    assign pos  = pos_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_multi_mode_ring_counter.sv
// Directed self-checking bench for multi_mode_ring_counter at N=4.
// Expectations for the self-correction case follow RING_SELF_CORRECT_EN when it is defined.
module tb_multi_mode_ring_counter;

    localparam int N  = 4;
    localparam int PW = $clog2(2*N);

    logic          clk;
    logic          reset;
    logic          en;
    logic          dir;
    logic          mode;
    logic          load;
    logic [N-1:0]  load_val;
    logic [N-1:0]  Q;
    logic [PW-1:0] pos;
    logic          wrap;
    logic          err;

    int errors;
    int checks;

    multi_mode_ring_counter #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .Q        (Q),
        .pos      (pos),
        .wrap     (wrap),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and leave time for registered outputs to settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset    = 1'b0;
        en       = 1'b0;
        dir      = 1'b0;
        load     = 1'b0;
        load_val = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        mode  = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        if ({Q, pos, wrap, err} !== {4'b0001, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_ring: Q=%b pos=%0d wrap=%b err=%b, want Q=0001 pos=0 wrap=0 err=0", Q, pos, wrap, err);
        end
        checks++;
    endtask

    task automatic test_ring_up();
        logic [N-1:0]  exp_q [5]    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [PW-1:0] exp_pos [5]  = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
        logic          exp_wrap [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        en  = 1'b1;
        dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if ({Q, pos, wrap} !== {exp_q[i], exp_pos[i], exp_wrap[i]}) begin
                errors++;
                $display("[TB] FAIL ring_up[%0d]: Q=%b pos=%0d wrap=%b, want Q=%b pos=%0d wrap=%b", i, Q, pos, wrap, exp_q[i], exp_pos[i], exp_wrap[i]);
            end
            checks++;
        end
        en = 1'b0;
    endtask

    task automatic test_hold();
        logic [N-1:0]  held_q;
        logic [PW-1:0] held_pos;
        held_q   = 4'b0010;
        held_pos = 3'd1;
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if ({Q, pos, wrap} !== {held_q, held_pos, 1'b0}) begin
                errors++;
                $display("[TB] FAIL hold[%0d]: Q=%b pos=%0d wrap=%b, want Q=%b pos=%0d wrap=0", i, Q, pos, wrap, held_q, held_pos);
            end
            checks++;
        end
    endtask

    task automatic test_johnson();
        logic [N-1:0] exp_q [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                    4'b1110, 4'b1100, 4'b1000, 4'b0000};
        idle_inputs();
        mode  = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        if ({Q, pos, wrap} !== {4'b0000, 3'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_johnson: Q=%b pos=%0d wrap=%b, want Q=0000 pos=0 wrap=0", Q, pos, wrap);
        end
        checks++;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if ({Q, pos, wrap} !== {exp_q[i], 3'((i + 1) % 8), (i == 7)}) begin
                errors++;
                $display("[TB] FAIL johnson[%0d]: Q=%b pos=%0d wrap=%b, want Q=%b pos=%0d wrap=%b", i, Q, pos, wrap, exp_q[i], (i + 1) % 8, (i == 7));
            end
            checks++;
        end
        // Backwards from the Johnson origin lands on pos 7 with a wrap.
        dir = 1'b1;
        step();
        if ({Q, pos, wrap} !== {4'b1000, 3'd7, 1'b1}) begin
            errors++;
            $display("[TB] FAIL johnson_down: Q=%b pos=%0d wrap=%b, want Q=1000 pos=7 wrap=1", Q, pos, wrap);
        end
        checks++;
        idle_inputs();
    endtask

    task automatic test_direction();
        idle_inputs();
        mode  = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        en    = 1'b1;
        dir   = 1'b1;
        step();
        if ({Q, pos, wrap} !== {4'b1000, 3'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL dir_down: Q=%b pos=%0d wrap=%b, want Q=1000 pos=3 wrap=1", Q, pos, wrap);
        end
        checks++;
        dir = 1'b0;
        step();
        if ({Q, pos, wrap} !== {4'b0001, 3'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL dir_up: Q=%b pos=%0d wrap=%b, want Q=0001 pos=0 wrap=1", Q, pos, wrap);
        end
        checks++;
        idle_inputs();
    endtask

    task automatic test_load_and_mode();
        en       = 1'b1;
        dir      = 1'b0;
        load     = 1'b1;
        load_val = 4'b0100;
        step();
        load = 1'b0;
        if ({Q, pos, wrap} !== {4'b0100, 3'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL load_vs_en: Q=%b pos=%0d wrap=%b, want Q=0100 pos=0 wrap=0", Q, pos, wrap);
        end
        checks++;
        step();
        if ({Q, pos} !== {4'b1000, 3'd1}) begin
            errors++;
            $display("[TB] FAIL after_load: Q=%b pos=%0d, want Q=1000 pos=1", Q, pos);
        end
        checks++;
        mode = 1'b1;
        step();
        if ({Q, pos, wrap} !== {4'b0000, 3'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mode_toggle: Q=%b pos=%0d wrap=%b, want Q=0000 pos=0 wrap=0", Q, pos, wrap);
        end
        checks++;
        step();
        if ({Q, pos} !== {4'b0001, 3'd1}) begin
            errors++;
            $display("[TB] FAIL after_toggle: Q=%b pos=%0d, want Q=0001 pos=1", Q, pos);
        end
        checks++;
        idle_inputs();
    endtask

    task automatic test_reset_priority();
        idle_inputs();
        mode  = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 3; i++) step();
        reset    = 1'b1;
        load     = 1'b1;
        load_val = 4'b1010;
        step();
        if ({Q, pos, wrap, err} !== {4'b0001, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_priority: Q=%b pos=%0d wrap=%b err=%b, want Q=0001 pos=0 wrap=0 err=0", Q, pos, wrap, err);
        end
        checks++;
        idle_inputs();
    endtask

    task automatic test_self_correct();
        logic [N-1:0]  exp_q;
        logic [PW-1:0] exp_pos;
        logic          exp_err;
`ifdef RING_SELF_CORRECT_EN
        exp_q   = 4'b0001;
        exp_pos = 3'd0;
        exp_err = 1'b1;
`else
        exp_q   = 4'b1100;
        exp_pos = 3'd1;
        exp_err = 1'b0;
`endif
        idle_inputs();
        mode     = 1'b0;
        load     = 1'b1;
        load_val = 4'b0110;
        step();
        load = 1'b0;
        en   = 1'b1;
        step();
        en = 1'b0;
        if ({Q, pos, err, wrap} !== {exp_q, exp_pos, exp_err, 1'b0}) begin
            errors++;
            $display("[TB] FAIL self_correct: Q=%b pos=%0d err=%b wrap=%b, want Q=%b pos=%0d err=%b wrap=0", Q, pos, err, wrap, exp_q, exp_pos, exp_err);
        end
        checks++;
        step();
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_width: err=%b, want 0", err);
        end
        checks++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle_inputs();
        mode = 1'b0;
        test_reset();
        test_ring_up();
        test_hold();
        test_johnson();
        test_direction();
        test_load_and_mode();
        test_reset_priority();
        test_self_correct();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
